// File: rtl/imem_responder_if.sv
`default_nettype none
// =============================================================================
// imem_responder_if : fetch request / response / program-load bundle
// Rev 1.0
// =============================================================================
interface imem_responder_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic [31:0]       req_addr;
   logic              req_ready;
   logic              resp_valid;
   logic [31:0]       resp_data;
   logic              resp_err;
   logic              resp_ready;
   logic              flush;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;

   modport master (
      output req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// =============================================================================
// imem_responder : instruction memory with fixed-latency delay line feeding a
//                  flushable in-order response FIFO
// Rev 1.0
// =============================================================================
module imem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  wire logic       clk,
   input  wire logic       rst,
   imem_responder_if.slave bus
);
   localparam int DEPTH = LATENCY + 2;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]        mem_q [2**ADDR_W];

   logic [LATENCY-1:0] dl_valid_q, dl_valid_d;
   logic [LATENCY-1:0] dl_err_q, dl_err_d;
   logic [31:0]        dl_data_q [LATENCY];
   logic [31:0]        dl_data_d [LATENCY];

   logic [31:0]        fifo_data_q [DEPTH];
   logic [31:0]        fifo_data_d [DEPTH];
   logic [DEPTH-1:0]   fifo_err_q, fifo_err_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;

   logic              accept, pop, push, req_err;
   logic [ADDR_W-1:0] req_word;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign req_word = bus.req_addr[ADDR_W+1:2];
   assign req_err  = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);

   // Only registered occupancy gates acceptance, so resp_ready never reaches req_ready.
   assign bus.req_ready  = !rst && !bus.flush && !bus.load_en && (outstanding_q < CNT_W'(DEPTH));
   assign bus.resp_valid = (fifo_cnt_q != '0);
   assign bus.resp_data  = bus.resp_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
   assign bus.resp_err   = bus.resp_valid && fifo_err_q[rd_ptr_q];

   assign accept = bus.req_valid && bus.req_ready;
   assign pop    = bus.resp_valid && bus.resp_ready && !bus.flush;
   assign push   = dl_valid_q[LATENCY-1];

   always_comb begin
      // The word is read at acceptance and travels with the request, so later loads cannot alter it.
      dl_valid_d   = '0;
      dl_err_d     = '0;
      dl_data_d    = dl_data_q;
      dl_valid_d[0] = accept;
      dl_err_d[0]   = req_err;
      dl_data_d[0]  = req_err ? 32'h0 : mem_q[req_word];
      for (int i = 1; i < LATENCY; i++) begin
         dl_valid_d[i] = dl_valid_q[i-1];
         dl_err_d[i]   = dl_err_q[i-1];
         dl_data_d[i]  = dl_data_q[i-1];
      end

      fifo_data_d   = fifo_data_q;
      fifo_err_d    = fifo_err_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(pop);
      if (push) begin
         fifo_data_d[wr_ptr_q] = dl_data_q[LATENCY-1];
         fifo_err_d[wr_ptr_q]  = dl_err_q[LATENCY-1];
         wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      if (bus.flush) begin
         dl_valid_d    = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         fifo_cnt_d    = '0;
         outstanding_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_valid_q    <= '0;
         dl_err_q      <= '0;
         fifo_err_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         outstanding_q <= '0;
         for (int i = 0; i < LATENCY; i++) dl_data_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_data_q[i] <= '0;
      end else begin
         dl_valid_q    <= dl_valid_d;
         dl_err_q      <= dl_err_d;
         dl_data_q     <= dl_data_d;
         fifo_data_q   <= fifo_data_d;
         fifo_err_q    <= fifo_err_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         outstanding_q <= outstanding_d;
      end
   end

   // Memory contents survive reset; only the write strobe is blocked while rst is high.
   always_ff @(posedge clk) begin
      if (bus.load_en && !rst) begin
         mem_q[bus.load_addr] <= bus.load_data;
      end
   end
endmodule
`default_nettype wire
